uart_tx_arbiter: RTL and testbench

- Shares one unbuffered UART transmitter among NUM_REQ byte-stream requesters.
- Arbitration is round-robin at message granularity: a grant is held from the first byte of a message until the byte flagged last has been fully shifted out, or until the holder stalls past a timeout.
- Sits between client logic (debug printers, status reporters) and the transmitter's send/data/busy interface.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART TX arbiter.
// The slave side is the arbiter. The master side is the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DAT_WIDTH = 8
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DAT_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]           req_last;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         tx_send;
   logic [DAT_WIDTH-1:0]         tx_data;
   logic                         tx_busy;
   logic                         grant_valid;
   logic [IDW-1:0]               grant_id;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_send, tx_data, grant_valid, grant_id
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_send, tx_data, grant_valid, grant_id
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one unbuffered UART transmitter.
// A grant lasts until the last byte clears the line, or until the holder stalls past IDLE_TIMEOUT.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DAT_WIDTH    = 8,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int TW  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_LOCKED    = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic           grant_valid_q, grant_valid_d;
   logic           last_q, last_d;
   logic [TW-1:0]  tmo_q, tmo_d;

   logic [NUM_REQ-1:0][DAT_WIDTH-1:0] req_arr;
   logic [IDW-1:0]                    win_id;
   logic                              sel_valid;
   logic                              locked;
   logic                              hs;

   // First valid index after p, wrapping; p itself is searched last.
   function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [IDW-1:0]     p);
      logic [IDW-1:0] sel;
      logic [IDW-1:0] cand;
      logic           hit;
      sel = '0;
      hit = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((int'(p) + k) % NUM_REQ);
         if (!hit && v[cand]) begin
            hit = 1'b1;
            sel = cand;
         end
      end
      return sel;
   endfunction

   assign req_arr   = bus.req_data;
   assign win_id    = rr_pick(bus.req_valid, rr_ptr_q);
   assign locked    = (state_q == S_LOCKED);
   assign sel_valid = bus.req_valid[grant_id_q];
   assign hs        = locked && sel_valid && !bus.tx_busy;

   assign bus.tx_send     = hs;
   assign bus.req_ready   = hs ? (NUM_REQ'(1) << grant_id_q) : '0;
   assign bus.tx_data     = locked ? req_arr[grant_id_q] : '0;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      last_d        = last_q;
      tmo_d         = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (|bus.req_valid) begin
               state_d       = S_LOCKED;
               grant_id_d    = win_id;
               rr_ptr_d      = win_id;
               grant_valid_d = 1'b1;
               tmo_d         = '0;
            end
         end
         S_LOCKED: begin
            if (hs) begin
               last_d  = bus.req_last[grant_id_q];
               tmo_d   = '0;
               state_d = S_WAIT_BUSY;
            end else if (!sel_valid && IDLE_TIMEOUT != 0) begin
               // Stalled holder: revoke. rr_ptr stays on it so it ranks last next time.
               if (tmo_q == TMO_LAST) begin
                  state_d       = S_IDLE;
                  grant_valid_d = 1'b0;
                  grant_id_d    = '0;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
         end
         S_WAIT_BUSY: state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (last_q) begin
                  state_d       = S_IDLE;
                  grant_valid_d = 1'b0;
                  grant_id_d    = '0;
               end else begin
                  state_d = S_LOCKED;
                  tmo_d   = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= IDW'(NUM_REQ - 1);
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         last_q        <= 1'b0;
         tmo_q         <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         last_q        <= last_d;
         tmo_q         <= tmo_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: message sources, a busy-counter transmitter model,
// a round-robin vector table and hand sequences for the multi-cycle corner cases.
module tb_uart_tx_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DAT_WIDTH(DW)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NR), .DAT_WIDTH(DW), .IDLE_TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      logic [NR-1:0] mask;
      int            exp_id;
      logic [7:0]    exp_data;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int viol   = 0;

   logic [7:0] mem [NR][8];
   int  len [NR];
   int  pos [NR];
   bit  en [NR];
   bit  rep [NR];
   bit  nolast [NR];
   int  busy_len = 3;
   int  busy_cnt = 0;
   bit  busy_force = 1'b0;
   bit  rst_v = 1'b1;
   bit  prev_send = 1'b0;
   bit  prev_gv = 1'b0;
   int          gq [$];
   logic [15:0] sq [$];
   int          sc [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs after the edge, then sample outputs and advance the models at negedge.
   task automatic cycle();
      logic [NR-1:0]    v, l, hm;
      logic [NR*DW-1:0] d;
      @(posedge clk);
      #1;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
         if (en[i] && pos[i] < len[i]) v = v | (NR'(1) << i);
         if (pos[i] == len[i] - 1 && !nolast[i]) l = l | (NR'(1) << i);
         d = d | ((NR*DW)'(mem[i][pos[i] % 8]) << (i * DW));
      end
      rst = rst_v;
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      bus.tx_busy   = busy_force || (busy_cnt != 0);
      @(negedge clk);
      cyc++;
      hm = bus.grant_valid ? (NR'(1) << bus.grant_id) : '0;
      if (|(bus.req_ready & ~hm)) viol++;
      if (bus.tx_send && (bus.tx_busy || prev_send)) viol++;
      prev_send = bus.tx_send;
      if (bus.grant_valid && !prev_gv) gq.push_back(int'(bus.grant_id));
      prev_gv = bus.grant_valid;
      if (bus.tx_send) begin
         sq.push_back({8'(bus.grant_id), bus.tx_data});
         sc.push_back(cyc);
      end
      for (int i = 0; i < NR; i++)
         if (((bus.req_valid & bus.req_ready) >> i) & NR'(1)) begin
            pos[i]++;
            if (rep[i] && pos[i] >= len[i]) pos[i] = 0;
         end
      if (bus.tx_send) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
   endtask

   // mode 0: grants seen >= val, 1: sends seen >= val, 2: grant_valid == val, 3: tx_busy == val
   task automatic wait_for(input int mode, input int val, input int bound, input string name);
      int k;
      bit ok;
      k = 0;
      forever begin
         case (mode)
            0:       ok = (gq.size() >= val);
            1:       ok = (sq.size() >= val);
            2:       ok = (bus.grant_valid === val[0]);
            default: ok = (bus.tx_busy === val[0]);
         endcase
         if (ok || k >= bound) break;
         cycle();
         k++;
      end
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL %s: no event after %0d cycles", name, bound);
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < NR; i++) begin
         en[i] = 0; pos[i] = 0; len[i] = 0; rep[i] = 0; nolast[i] = 0;
      end
   endtask

   task automatic do_reset();
      clear_src();
      busy_force = 0;
      busy_cnt   = 0;
      rst_v      = 1;
      cycle();
      cycle();
      rst_v = 0;
      cycle();
      gq.delete(); sq.delete(); sc.delete();
   endtask

   vec_t tv [9];
   int   rr_exp [6];
   int   t0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{4'b1111, 0, 8'hA0};
      tv[1] = '{4'b1111, 1, 8'hA1};
      tv[2] = '{4'b1001, 3, 8'hA3};
      tv[3] = '{4'b0110, 1, 8'hA1};
      tv[4] = '{4'b0001, 0, 8'hA0};
      tv[5] = '{4'b0001, 0, 8'hA0};
      tv[6] = '{4'b1100, 2, 8'hA2};
      tv[7] = '{4'b0101, 0, 8'hA0};
      tv[8] = '{4'b1000, 3, 8'hA3};
      rr_exp = '{0, 1, 3, 0, 1, 3};

      rst = 1'b1;
      bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_busy = 1'b0;
      for (int i = 0; i < NR; i++) for (int j = 0; j < 8; j++) mem[i][j] = 8'h00;
      clear_src();

      // Reset state, with a requester already asserting valid.
      mem[0][0] = 8'h41; mem[0][1] = 8'h42; mem[0][2] = 8'h43;
      len[0] = 3; en[0] = 1; busy_len = 40; rst_v = 1;
      cycle(); cycle();
      chk("rst_grant_valid", 32'(bus.grant_valid), 0);
      chk("rst_grant_id", 32'(bus.grant_id), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_tx_send", 32'(bus.tx_send), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      rst_v = 0;
      cycle();
      gq.delete(); sq.delete(); sc.delete();
      chk("idle_no_grant_yet", 32'(bus.grant_valid), 0);
      cycle();
      chk("grant_latency_valid", 32'(bus.grant_valid), 1);
      chk("grant_latency_id", 32'(bus.grant_id), 0);

      // Single three-byte message against a 40-cycle transmitter.
      wait_for(1, 3, 300, "single_sends");
      for (int k = 0; k < 3 && k < sq.size(); k++)
         chk($sformatf("single_byte%0d", k), 32'(sq[k]), 32'({8'h00, 8'h41 + 8'(k)}));
      if (sc.size() >= 3) begin
         chk("single_gap01", 32'(sc[1] - sc[0]), 42);
         chk("single_gap12", 32'(sc[2] - sc[1]), 42);
      end
      wait_for(3, 1, 10, "single_busy_rise");
      wait_for(3, 0, 60, "single_busy_fall");
      chk("single_held_at_fall", 32'(bus.grant_valid), 1);
      cycle();
      chk("single_released", 32'(bus.grant_valid), 0);

      // Round-robin vector table, one-byte messages from each masked requester.
      do_reset();
      busy_len = 3;
      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < NR; i++) begin
            mem[i][0] = 8'hA0 + 8'(i); len[i] = 1; pos[i] = 0; en[i] = tv[v].mask[i];
         end
         gq.delete(); sq.delete();
         wait_for(0, 1, 10, $sformatf("tv%0d_grant", v));
         if (gq.size() > 0) chk($sformatf("tv%0d_id", v), 32'(gq[0]), 32'(tv[v].exp_id));
         wait_for(1, 1, 10, $sformatf("tv%0d_send", v));
         if (sq.size() > 0) chk($sformatf("tv%0d_data", v), 32'(sq[0][7:0]), 32'(tv[v].exp_data));
         for (int i = 0; i < NR; i++) en[i] = 0;
         wait_for(2, 0, 20, $sformatf("tv%0d_release", v));
      end

      // Continuous requesters 0, 1, 3.
      do_reset();
      for (int i = 0; i < NR; i++) begin
         mem[i][0] = 8'hA0 + 8'(i); len[i] = 1; rep[i] = 1; en[i] = (i != 2);
      end
      wait_for(0, 6, 200, "rr_grants");
      for (int k = 0; k < 6 && k < gq.size(); k++)
         chk($sformatf("rr_order%0d", k), 32'(gq[k]), 32'(rr_exp[k]));
      clear_src();
      wait_for(2, 0, 20, "rr_release");

      // Message atomicity: req 1 keeps the line for all four bytes.
      do_reset();
      for (int k = 0; k < 4; k++) mem[1][k] = 8'h10 + 8'(k);
      len[1] = 4; en[1] = 1;
      wait_for(0, 1, 10, "atom_grant");
      if (gq.size() > 0) chk("atom_first_id", 32'(gq[0]), 1);
      mem[0][0] = 8'h55; len[0] = 1; en[0] = 1;
      wait_for(1, 5, 200, "atom_sends");
      for (int k = 0; k < 4 && k < sq.size(); k++)
         chk($sformatf("atom_byte%0d", k), 32'(sq[k]), 32'({8'h01, 8'h10 + 8'(k)}));
      if (sq.size() >= 5) chk("atom_req0_after", 32'(sq[4]), 32'(16'h0055));
      wait_for(2, 0, 30, "atom_release");

      // Timeout: req 2 sends one non-last byte then goes quiet.
      do_reset();
      mem[2][0] = 8'h77; len[2] = 1; nolast[2] = 1; en[2] = 1;
      mem[3][0] = 8'h33; len[3] = 1; en[3] = 1;
      wait_for(1, 1, 10, "to_send");
      if (gq.size() > 0) chk("to_first_id", 32'(gq[0]), 2);
      t0 = (sc.size() > 0) ? sc[0] + busy_len + 2 : cyc;
      while (cyc < t0 + 15) cycle();
      chk("to_held_16th", 32'(bus.grant_valid), 1);
      cycle();
      chk("to_dropped", 32'(bus.grant_valid), 0);
      cycle();
      chk("to_next_valid", 32'(bus.grant_valid), 1);
      chk("to_next_id", 32'(bus.grant_id), 3);
      wait_for(2, 0, 30, "to_release");

      // Reset during WAIT_DONE of byte 2 of 5.
      do_reset();
      busy_len = 10;
      for (int k = 0; k < 5; k++) mem[1][k] = 8'h21 + 8'(k);
      len[1] = 5; en[1] = 1;
      wait_for(1, 2, 100, "mid_two_sends");
      repeat (4) cycle();
      chk("mid_held_before_rst", 32'(bus.grant_valid), 1);
      rst_v = 1;
      mem[0][0] = 8'h5A; len[0] = 1; en[0] = 1;
      mem[2][0] = 8'h5C; len[2] = 1; en[2] = 1;
      cycle();
      cycle();
      chk("mid_rst_grant_valid", 32'(bus.grant_valid), 0);
      chk("mid_rst_tx_send", 32'(bus.tx_send), 0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 0);
      rst_v = 0; en[1] = 0;
      gq.delete(); sq.delete();
      wait_for(0, 1, 20, "mid_regrant");
      if (gq.size() > 0) chk("mid_rr_reset_winner", 32'(gq[0]), 0);
      wait_for(2, 0, 80, "mid_release");

      // Send safety: transmitter held busy while req 0 is granted and valid.
      do_reset();
      busy_force = 1;
      mem[0][0] = 8'h99; len[0] = 1; en[0] = 1;
      wait_for(0, 1, 10, "safe_grant");
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk($sformatf("safe_no_send%0d", k), 32'(bus.tx_send), 0);
         chk($sformatf("safe_no_ready%0d", k), 32'(bus.req_ready), 0);
      end
      busy_force = 0;
      cycle();
      chk("safe_send", 32'(bus.tx_send), 1);
      chk("safe_data", 32'(bus.tx_data), 32'h99);
      cycle();
      chk("safe_single_pulse", 32'(bus.tx_send), 0);
      wait_for(2, 0, 20, "safe_release");

      chk("protocol_monitor_violations", 32'(viol), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
